// File: rtl/alu_muldiv.sv
// Multi-cycle multiply/divide unit with HI/LO result registers.
// Operands are captured at issue; HI/LO are written when the busy countdown expires.
//
// state | meaning
// IDLE  | accepting issues; MTHI/MTLO write immediately
// RUN   | multiply/divide in flight, counter running down to retirement
module alu_muldiv #(
    parameter int WIDTH      = 32,
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             start_i,
    input  logic [2:0]       op_i,
    input  logic [WIDTH-1:0] num1_i,
    input  logic [WIDTH-1:0] num2_i,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             op_invalid_o
);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;
    localparam logic [2:0] OP_RSVD  = 3'd7;

    localparam int MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
    logic [2:0]         op_q, op_d;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic               busy_q, busy_d, done_q, done_d, inv_q, inv_d;

    logic [2*WIDTH-1:0]       a_sx, b_sx, a_zx, b_zx, prod_s, prod_u;
    logic signed [WIDTH-1:0]  sa, sb, sq, sr;
    logic [WIDTH-1:0]         uq, ur, res_hi, res_lo;

    // Result is formed from the latched operands only; inputs are ignored while running.
    always_comb begin
        a_sx   = {{WIDTH{a_q[WIDTH-1]}}, a_q};
        b_sx   = {{WIDTH{b_q[WIDTH-1]}}, b_q};
        a_zx   = {{WIDTH{1'b0}}, a_q};
        b_zx   = {{WIDTH{1'b0}}, b_q};
        prod_s = a_sx * b_sx;
        prod_u = a_zx * b_zx;
        sa     = $signed(a_q);
        sb     = $signed(b_q);
        sq     = '0;
        sr     = '0;
        uq     = '0;
        ur     = '0;
        if (b_q != '0) begin
            sq = sa / sb;
            sr = sa % sb;
            uq = a_q / b_q;
            ur = a_q % b_q;
        end
        res_hi = '0;
        res_lo = '0;
        case (op_q)
            OP_MULT: begin
                res_hi = prod_s[2*WIDTH-1:WIDTH];
                res_lo = prod_s[WIDTH-1:0];
            end
            OP_MULTU: begin
                res_hi = prod_u[2*WIDTH-1:WIDTH];
                res_lo = prod_u[WIDTH-1:0];
            end
            OP_DIV: begin
                if (b_q == '0) begin
                    res_hi = a_q;
                    res_lo = ALL_ONES;
                end else if (a_q == MOST_NEG && b_q == ALL_ONES) begin
                    res_hi = '0;
                    res_lo = a_q;
                end else begin
                    res_hi = sr;
                    res_lo = sq;
                end
            end
            OP_DIVU: begin
                if (b_q == '0) begin
                    res_hi = a_q;
                    res_lo = ALL_ONES;
                end else begin
                    res_hi = ur;
                    res_lo = uq;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        inv_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    case (op_i)
                        OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                            a_d     = num1_i;
                            b_d     = num2_i;
                            op_d    = op_i;
                            cnt_d   = (op_i == OP_MULT || op_i == OP_MULTU) ?
                                      CNT_W'(MUL_CYCLES) : CNT_W'(DIV_CYCLES);
                            busy_d  = 1'b1;
                            state_d = RUN;
                        end
                        OP_MTHI: hi_d  = num1_i;
                        OP_MTLO: lo_d  = num1_i;
                        OP_RSVD: inv_d = 1'b1;
                        default: ;
                    endcase
                end
            end
            RUN: begin
                cnt_d = cnt_q - CNT_W'(1);
                // Any issue attempt while running is rejected, even MTHI/MTLO.
                if (start_i) inv_d = 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    hi_d    = res_hi;
                    lo_d    = res_lo;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            inv_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            inv_q   <= inv_d;
        end
    end

    assign hi_o         = hi_q;
    assign lo_o         = lo_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign op_invalid_o = inv_q;

endmodule

// File: doc/alu_muldiv.md
# alu_muldiv

Parametrised multi-cycle multiply/divide unit with HI/LO result registers, the sequential companion to the combinational ALU in the datapath. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO operations on a start pulse and holds the pipeline via `busy` for a configurable latency. It captures operands at issue and writes HI/LO when the operation retires.

## Interface
- `WIDTH`, 32: operand and HI/LO width; must be ≥ 2.
- `MUL_CYCLES`, 5: busy cycles for MULT/MULTU; must be ≥ 1.
- `DIV_CYCLES`, 10: busy cycles for DIV/DIVU; must be ≥ 1.
- `clk` in 1: single clock, all state on rising edge.
- `reset` in 1: asynchronous, active-high; clears all state immediately.
- `start` in 1: issue strobe, sampled on the rising edge.
- `op` in 3: operation code.
  - 0: NOP.
  - 1: MULT.
  - 2: MULTU.
  - 3: DIV.
  - 4: DIVU.
  - 5: MTHI.
  - 6: MTLO.
  - 7: reserved.
- `num1` in WIDTH: operand A, dividend, or MTHI/MTLO source.
- `num2` in WIDTH: operand B or divisor.
- `hi` out WIDTH: HI register.
- `lo` out WIDTH: LO register.
- `busy` out 1: a multiply or divide is in flight.
- `done` out 1: one-cycle pulse in the first cycle the new HI/LO are visible.
- `op_invalid` out 1: registered one-cycle flag for a rejected issue.

## Operation
- Reset values: `hi`=0, `lo`=0, `busy`=0, `done`=0, `op_invalid`=0, state IDLE, counter 0.
- Reset mid-operation aborts the operation with no HI/LO write.
- There are two states, IDLE and RUN.

Behaviour in IDLE when `start` is sampled high:
- MULT/MULTU:
  - Latch `num1`, `num2` and op.
  - Load the counter with `MUL_CYCLES`.
  - Go to RUN.
- DIV/DIVU: same as MULT/MULTU, but load the counter with `DIV_CYCLES`.
- MTHI: `hi` ← `num1` at that edge; `lo` unchanged; no busy; no done.
- MTLO: `lo` ← `num1` at that edge; `hi` unchanged; no busy; no done.
- NOP: no effect.
- Reserved op: no state change; `op_invalid`=1 next cycle.

Behaviour in RUN:
- The counter decrements each edge.
- On the edge where the counter goes from 1 to 0:
  - HI/LO are written.
  - `busy` goes to 0.
  - `done` is 1 for one cycle.
  - State returns to IDLE.
- Any `start` sampled in RUN, including MTHI/MTLO, is dropped: no HI/LO change and `op_invalid`=1 next cycle. The in-flight operation continues unaffected.
- Operand inputs are ignored in RUN; only the latched copies are used.
- `hi`/`lo` hold their previous values throughout RUN.

Arithmetic rules (result computed on the 2·WIDTH product or WIDTH quotient/remainder):
- MULT: signed × signed full 2·WIDTH product; `hi`=upper WIDTH bits, `lo`=lower WIDTH bits.
- MULTU: the same, unsigned.
- DIV: signed; `lo`=quotient truncated toward zero; `hi`=remainder with the sign of the dividend.
- DIVU: unsigned; `lo`=quotient; `hi`=remainder.
- Divide by zero (DIV and DIVU): `lo`=all ones, `hi`=dividend. There is no other flag.
- Signed overflow (DIV with dividend = most-negative value and divisor = −1): `lo`=dividend, `hi`=0.

## Timing
- Multiply/divide issue: `start` is sampled at edge k.
  - `busy`=1 for cycles k+1 … k+N, where N = `MUL_CYCLES` or `DIV_CYCLES`.
  - At edge k+N, `hi`/`lo` are updated, `busy`=0 and `done`=1.
  - In cycle k+N+1, `done`=0.
- Back-to-back issue: a new `start` is accepted in the same cycle `done`=1, since the unit is in IDLE by then.
- MTHI/MTLO: the written value is visible in the cycle after the sampling edge, i.e. latency 1.
- `op_invalid` is registered: high exactly one cycle after the offending edge, then low unless re-triggered.
- `busy`, `done` and `op_invalid` are all register outputs with no combinational path from inputs.

## Test plan
- Reset, then MULT with `num1`=0xFFFFFFFF (−1) and `num2`=0x00000002, default parameters:
  - `busy` is high for 5 cycles.
  - Then `hi`=0xFFFFFFFF, `lo`=0xFFFFFFFE, with a single-cycle `done`.
- MULTU with the same operands: `hi`=0x00000001, `lo`=0xFFFFFFFE after 5 busy cycles.
- DIV with `num1`=−7 (0xFFFFFFF9) and `num2`=2:
  - `lo`=0xFFFFFFFD (−3), `hi`=0xFFFFFFFF (−1) after 10 busy cycles.
- DIVU with `num2`=0 and `num1`=0x1234: `lo`=0xFFFFFFFF, `hi`=0x1234.
- DIV 0x80000000 / 0xFFFFFFFF: `lo`=0x80000000, `hi`=0.
- During a DIV, pulse `start` with MTLO 0xAAAA and change `num1`/`num2`:
  - `op_invalid` is high for 1 cycle.
  - The final result is unchanged.
  - `lo`≠0xAAAA.
- Reset asserted mid-MULT: `busy`, `hi`, `lo` and `done` are 0 immediately, and no `done` pulse follows.
- Back-to-back issue: MTHI 0x55 issued in the `done` cycle of a MULT gives `hi`=0x55 next cycle.
- Parameter check: with `WIDTH`=8 and `MUL_CYCLES`=1, MULT of 0x80 × 0x80 gives `hi`=0x40, `lo`=0x00 with 1 busy cycle.
